// File: rtl/sd_fifo_tx_burst_filler_if.sv
// Wishbone read-master bus between the SD TX burst filler and system memory.
interface sd_fifo_tx_burst_filler_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic [AW-1:0]   m_wb_adr_o;
  logic [DW/8-1:0] m_wb_sel_o;
  logic            m_wb_we_o;
  logic            m_wb_cyc_o;
  logic            m_wb_stb_o;
  logic [2:0]      m_wb_cti_o;
  logic [1:0]      m_wb_bte_o;
  logic [DW-1:0]   m_wb_dat_i;
  logic            m_wb_ack_i;
  logic            m_wb_err_i;

  modport master (
    output m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    input  m_wb_dat_i, m_wb_ack_i, m_wb_err_i
  );

  modport slave (
    input  m_wb_adr_o, m_wb_sel_o, m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, m_wb_cti_o, m_wb_bte_o,
    output m_wb_dat_i, m_wb_ack_i, m_wb_err_i
  );
endinterface

// File: rtl/sd_fifo_tx_burst_filler.sv
// Prefetches one SD write transfer from memory into the TX FIFO with incrementing Wishbone bursts.
// Each acked word reaches the FIFO one cycle later; a burst starts only once the FIFO can hold all of it.
module sd_fifo_tx_burst_filler #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int BURST_LEN = 4,
  parameter int CNT_W     = 16,
  parameter int FREE_W    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [AW-1:0]         adr,
  input  logic [CNT_W-1:0]      len,
  sd_fifo_tx_burst_filler_if.master wb,
  output logic [DW-1:0]         fifo_din,
  output logic                  fifo_wr,
  input  logic [FREE_W-1:0]     fifo_free,
  output logic                  fifo_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int               BW          = $clog2(BURST_LEN + 1);
  localparam int               CW          = (CNT_W > FREE_W) ? CNT_W : FREE_W;
  localparam logic [CNT_W-1:0] BURST_LEN_C = CNT_W'(BURST_LEN);
  localparam logic [AW-1:0]    STEP        = AW'(DW / 8);
  localparam logic [2:0]       CTI_INC     = 3'b010;
  localparam logic [2:0]       CTI_END     = 3'b111;

  typedef enum logic [2:0] {IDLE, WAIT, BURST, DONE, ERR} state_t;

  state_t            state;
  logic [AW-1:0]     addr;
  logic [CNT_W-1:0]  remain;
  logic [BW-1:0]     beats;
  logic              cyc;
  logic              stb;
  logic [2:0]        cti;
  logic [CNT_W-1:0]  n_beats;
  logic [FREE_W-1:0] eff_free;
  logic              room;

  // The word written this cycle is not yet reflected in fifo_free, so reserve it here.
  always_comb begin
    n_beats  = (remain < BURST_LEN_C) ? remain : BURST_LEN_C;
    eff_free = (fifo_wr && fifo_free != '0) ? fifo_free - FREE_W'(1) : fifo_free;
    room     = CW'(eff_free) >= CW'(n_beats);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      remain   <= '0;
      beats    <= '0;
      cyc      <= 1'b0;
      stb      <= 1'b0;
      cti      <= 3'b000;
      fifo_din <= '0;
      fifo_wr  <= 1'b0;
      fifo_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      fifo_wr <= 1'b0;
      if (!en) begin
        state    <= IDLE;
        cyc      <= 1'b0;
        stb      <= 1'b0;
        cti      <= 3'b000;
        busy     <= 1'b0;
        done     <= 1'b0;
        err      <= 1'b0;
        fifo_rst <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            addr     <= adr;
            remain   <= len;
            fifo_rst <= 1'b0;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= WAIT;
              busy  <= 1'b1;
            end
          end
          WAIT: begin
            if (room) begin
              cyc   <= 1'b1;
              stb   <= 1'b1;
              beats <= BW'(n_beats);
              cti   <= (n_beats > CNT_W'(1)) ? CTI_INC : CTI_END;
              state <= BURST;
            end
          end
          BURST: begin
            // A bus error overrides a simultaneous ack; that beat is dropped.
            if (wb.m_wb_err_i) begin
              cyc   <= 1'b0;
              stb   <= 1'b0;
              cti   <= 3'b000;
              busy  <= 1'b0;
              err   <= 1'b1;
              state <= ERR;
            end else if (wb.m_wb_ack_i) begin
              fifo_din <= wb.m_wb_dat_i;
              fifo_wr  <= 1'b1;
              addr     <= addr + STEP;
              remain   <= remain - CNT_W'(1);
              beats    <= beats - BW'(1);
              if (beats == BW'(2)) cti <= CTI_END;
              if (beats == BW'(1)) begin
                cyc <= 1'b0;
                stb <= 1'b0;
                cti <= 3'b000;
                if (remain == CNT_W'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                end else begin
                  state <= WAIT;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wb.m_wb_adr_o = addr;
  assign wb.m_wb_sel_o = '1;
  assign wb.m_wb_we_o  = 1'b0;
  assign wb.m_wb_cyc_o = cyc;
  assign wb.m_wb_stb_o = stb;
  assign wb.m_wb_cti_o = cti;
  assign wb.m_wb_bte_o = 2'b00;
endmodule

// File: tb/tb_sd_fifo_tx_burst_filler.sv
// Bench for the SD TX burst filler: random Wishbone slave, FIFO occupancy model and per-beat scoreboard.
module tb_sd_fifo_tx_burst_filler;
  localparam int DW = 32, AW = 32, BURST_LEN = 4, CNT_W = 16, FREE_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [AW-1:0]    adr = '0;
  logic [CNT_W-1:0] len = '0;
  logic [DW-1:0]    fifo_din;
  logic             fifo_wr, fifo_rst, busy, done, err;
  logic [FREE_W-1:0] fifo_free;

  sd_fifo_tx_burst_filler_if #(.DW(DW), .AW(AW)) wb ();

  sd_fifo_tx_burst_filler #(.DW(DW), .AW(AW), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W), .FREE_W(FREE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .adr(adr), .len(len), .wb(wb),
    .fifo_din(fifo_din), .fifo_wr(fifo_wr), .fifo_free(fifo_free),
    .fifo_rst(fifo_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  logic ack_gate = 1'b1;
  bit   rand_wait = 0, drain = 1;
  int   err_at = -1, free_cap = 16, occ = 0;
  int   beat_k = 0, wr_k = 0, bursts = 0, xfer_len = 0;
  logic [AW-1:0] xfer_adr = '0, last_adr = '0;
  bit   acc_now = 0, wr_exp = 0;
  logic cyc_d = 1'b0;
  logic [2:0] exp_cti;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return DW'((a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F);
  endfunction

  // Memory slave: data is a hash of the address; acks stall randomly when rand_wait is set.
  assign wb.m_wb_ack_i = wb.m_wb_cyc_o & wb.m_wb_stb_o & ack_gate;
  assign wb.m_wb_err_i = wb.m_wb_cyc_o & wb.m_wb_stb_o & (beat_k == err_at);
  assign wb.m_wb_dat_i = mem(wb.m_wb_adr_o);
  assign fifo_free     = FREE_W'(free_cap - occ);

  always @(posedge clk) begin
    int pop;
    pop = 0;
    if (fifo_rst) occ <= 0;
    else begin
      if (drain && occ > 0 && $urandom_range(0, 1) == 1) pop = 1;
      if (fifo_wr) begin
        n_cmp++;
        if (occ >= free_cap) begin
          n_bad++;
          $display("FAIL fifo_overflow: occupancy %0d, capacity %0d", occ, free_cap);
        end
      end
      occ <= occ + (fifo_wr ? 1 : 0) - pop;
    end
  end

  always @(posedge clk) begin
    #1;
    if (acc_now) beat_k++;
    ack_gate = rand_wait ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Scoreboard: beat k of a transfer is at adr+4k, ends a burst every BURST_LEN beats or at the last word.
  always @(negedge clk) begin
    n_cmp++;
    if (wr_exp) begin
      if (fifo_wr !== 1'b1 || fifo_din !== mem(xfer_adr + AW'((DW / 8) * wr_k))) begin
        n_bad++;
        $display("FAIL fifo_write %0d: wr=%b din=%h, want wr=1 din=%h", wr_k, fifo_wr, fifo_din,
                 mem(xfer_adr + AW'((DW / 8) * wr_k)));
      end
      wr_k++;
    end else if (fifo_wr !== 1'b0) begin
      n_bad++;
      $display("FAIL spurious_write: fifo_wr=%b, want 0", fifo_wr);
    end
    acc_now = !rst && en && wb.m_wb_cyc_o && wb.m_wb_stb_o && wb.m_wb_ack_i && !wb.m_wb_err_i;
    if (acc_now) begin
      exp_cti = ((beat_k % BURST_LEN) == BURST_LEN - 1 || beat_k == xfer_len - 1) ? 3'b111 : 3'b010;
      n_cmp++;
      if (wb.m_wb_adr_o !== xfer_adr + AW'((DW / 8) * beat_k) || wb.m_wb_cti_o !== exp_cti) begin
        n_bad++;
        $display("FAIL beat %0d: adr=%h cti=%b, want adr=%h cti=%b", beat_k, wb.m_wb_adr_o,
                 wb.m_wb_cti_o, xfer_adr + AW'((DW / 8) * beat_k), exp_cti);
      end
      last_adr = wb.m_wb_adr_o;
    end
    if (wb.m_wb_cyc_o && !cyc_d) bursts++;
    cyc_d  = wb.m_wb_cyc_o;
    wr_exp = acc_now;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic start(input logic [AW-1:0] a, input int l);
    adr = a; len = CNT_W'(l); xfer_adr = a; xfer_len = l;
    beat_k = 0; wr_k = 0; bursts = 0; en = 1'b1;
  endtask

  task automatic stop();
    en = 1'b0;
    step(); step();
  endtask

  task automatic test_reset();
    step(); step();
    n_cmp++; if (wb.m_wb_cyc_o !== 1'b0 || wb.m_wb_stb_o !== 1'b0 || wb.m_wb_we_o !== 1'b0) begin
      n_bad++; $display("FAIL reset_bus: cyc=%b stb=%b we=%b, want 0", wb.m_wb_cyc_o, wb.m_wb_stb_o, wb.m_wb_we_o); end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || fifo_wr !== 1'b0) begin
      n_bad++; $display("FAIL reset_status: busy=%b done=%b err=%b wr=%b, want 0", busy, done, err, fifo_wr); end
    n_cmp++; if (fifo_rst !== 1'b1) begin n_bad++; $display("FAIL reset_fifo_rst: %b, want 1", fifo_rst); end
    n_cmp++; if (wb.m_wb_adr_o !== '0 || wb.m_wb_cti_o !== 3'b000 || fifo_din !== '0) begin
      n_bad++; $display("FAIL reset_regs: adr=%h cti=%b din=%h, want 0", wb.m_wb_adr_o, wb.m_wb_cti_o, fifo_din); end
    n_cmp++; if (wb.m_wb_sel_o !== 4'hF || wb.m_wb_bte_o !== 2'b00) begin
      n_bad++; $display("FAIL reset_sel_bte: sel=%h bte=%b, want f/00", wb.m_wb_sel_o, wb.m_wb_bte_o); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    start(32'h1000, 8);
    step();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: %b, want 1", busy); end
    for (int i = 0; i < 200 && done !== 1'b1; i++) step();
    step();
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_done: done=%b busy=%b, want 1/0", done, busy); end
    n_cmp++; if (wr_k !== 8 || bursts !== 2) begin n_bad++; $display("FAIL basic_count: words=%0d bursts=%0d, want 8/2", wr_k, bursts); end
    stop();
    n_cmp++; if (done !== 1'b0 || fifo_rst !== 1'b1) begin n_bad++; $display("FAIL basic_release: done=%b fifo_rst=%b, want 0/1", done, fifo_rst); end
  endtask

  task automatic test_lengths();
    int lens [3];
    lens = '{6, 1, 0};
    for (int t = 0; t < 3; t++) begin
      start(32'h0000_2000 + 32'(t * 256), lens[t]);
      if (lens[t] == 0) begin
        step();
        n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || wb.m_wb_cyc_o !== 1'b0) begin
          n_bad++; $display("FAIL len0: done=%b busy=%b cyc=%b, want 1/0/0", done, busy, wb.m_wb_cyc_o); end
        step(); step();
      end else begin
        for (int i = 0; i < 200 && done !== 1'b1; i++) step();
        step();
      end
      n_cmp++; if (done !== 1'b1 || wr_k !== lens[t] || bursts !== (lens[t] + BURST_LEN - 1) / BURST_LEN) begin
        n_bad++; $display("FAIL len%0d: done=%b words=%0d bursts=%0d, want 1/%0d/%0d", lens[t], done, wr_k, bursts,
                          lens[t], (lens[t] + BURST_LEN - 1) / BURST_LEN); end
      stop();
    end
  endtask

  task automatic test_random();
    int l;
    rand_wait = 1;
    for (int t = 0; t < 8; t++) begin
      free_cap = $urandom_range(BURST_LEN, 31);
      l = $urandom_range(1, 24);
      start($urandom & 32'hFFFF_FFFC, l);
      for (int i = 0; i < l * 40 + 100 && done !== 1'b1; i++) step();
      step();
      n_cmp++; if (done !== 1'b1 || wr_k !== l || beat_k !== l) begin
        n_bad++; $display("FAIL random_%0d: done=%b words=%0d beats=%0d, want 1/%0d/%0d", t, done, wr_k, beat_k, l, l); end
      stop();
    end
    rand_wait = 0;
    free_cap = 16;
  endtask

  task automatic test_backpressure();
    int early;
    drain = 0; free_cap = 3; early = 0;
    start(32'h3000, 8);
    for (int i = 0; i < 10; i++) begin
      step();
      if (wb.m_wb_cyc_o !== 1'b0) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL bp_hold: cyc high %0d cycles, want 0", early); end
    free_cap = 4;
    step();
    n_cmp++; if (wb.m_wb_cyc_o !== 1'b1) begin n_bad++; $display("FAIL bp_start: cyc=%b, want 1", wb.m_wb_cyc_o); end
    for (int i = 0; i < 10; i++) step();
    n_cmp++; if (wr_k !== 4 || wb.m_wb_cyc_o !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL bp_full: words=%0d cyc=%b busy=%b, want 4/0/1", wr_k, wb.m_wb_cyc_o, busy); end
    drain = 1; free_cap = 16;
    for (int i = 0; i < 200 && done !== 1'b1; i++) step();
    step();
    n_cmp++; if (done !== 1'b1 || wr_k !== 8) begin n_bad++; $display("FAIL bp_done: done=%b words=%0d, want 1/8", done, wr_k); end
    stop();
  endtask

  task automatic test_err();
    err_at = 1;
    start(32'h4000, 8);
    for (int i = 0; i < 100 && err !== 1'b1; i++) step();
    n_cmp++; if (err !== 1'b1 || busy !== 1'b0 || wb.m_wb_cyc_o !== 1'b0) begin
      n_bad++; $display("FAIL err_flag: err=%b busy=%b cyc=%b, want 1/0/0", err, busy, wb.m_wb_cyc_o); end
    step(); step(); step();
    n_cmp++; if (wr_k !== 1 || err !== 1'b1 || done !== 1'b0) begin
      n_bad++; $display("FAIL err_hold: words=%0d err=%b done=%b, want 1/1/0", wr_k, err, done); end
    err_at = -1;
    en = 1'b0;
    step();
    n_cmp++; if (err !== 1'b0 || fifo_rst !== 1'b1) begin n_bad++; $display("FAIL err_clear: err=%b fifo_rst=%b, want 0/1", err, fifo_rst); end
    step();
  endtask

  task automatic test_abort();
    start(32'h5000, 8);
    for (int i = 0; i < 100 && beat_k < 2; i++) step();
    en = 1'b0;
    step();
    n_cmp++; if (wb.m_wb_cyc_o !== 1'b0 || fifo_rst !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL abort_stop: cyc=%b fifo_rst=%b busy=%b, want 0/1/0", wb.m_wb_cyc_o, fifo_rst, busy); end
    step(); step();
    n_cmp++; if (wr_k !== 2) begin n_bad++; $display("FAIL abort_words: %0d, want 2", wr_k); end
    start(32'h6000, 3);
    for (int i = 0; i < 100 && done !== 1'b1; i++) step();
    step();
    n_cmp++; if (done !== 1'b1 || wr_k !== 3 || last_adr !== 32'h6008) begin
      n_bad++; $display("FAIL abort_restart: done=%b words=%0d last=%h, want 1/3/6008", done, wr_k, last_adr); end
    stop();
  endtask

  task automatic test_rst_wrap();
    start(32'h7000, 8);
    for (int i = 0; i < 100 && beat_k < 2; i++) step();
    #1 rst = 1'b1;
    wr_exp = 0;
    en = 1'b0;
    #1;
    n_cmp++; if (wb.m_wb_cyc_o !== 1'b0 || wb.m_wb_stb_o !== 1'b0 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_async_bus: cyc=%b stb=%b wr=%b busy=%b, want 0", wb.m_wb_cyc_o, wb.m_wb_stb_o, fifo_wr, busy); end
    n_cmp++; if (fifo_rst !== 1'b1 || wb.m_wb_adr_o !== '0 || wb.m_wb_cti_o !== 3'b000) begin
      n_bad++; $display("FAIL rst_async_regs: fifo_rst=%b adr=%h cti=%b, want 1/0/000", fifo_rst, wb.m_wb_adr_o, wb.m_wb_cti_o); end
    step();
    rst = 1'b0;
    step();
    start(32'hFFFF_FFFC, 2);
    for (int i = 0; i < 100 && done !== 1'b1; i++) step();
    step();
    n_cmp++; if (done !== 1'b1 || wr_k !== 2 || last_adr !== 32'h0000_0000) begin
      n_bad++; $display("FAIL wrap: done=%b words=%0d last=%h, want 1/2/00000000", done, wr_k, last_adr); end
    stop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lengths();
    test_random();
    test_backpressure();
    test_err();
    test_abort();
    test_rst_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
